// File: rtl/lsq_pkg.sv
// Shared types for the LSQ data-memory arbiter: command, requester and state encodings.
// Latency: none (types and a pure helper function only).
// Backpressure: not applicable.
package lsq_pkg;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        LOAD  = 2'd1,
        STORE = 2'd2
    } mem_cmd_e;

    typedef enum logic [1:0] {
        REQ_ST1 = 2'd0,
        REQ_ST2 = 2'd1,
        REQ_LD  = 2'd2
    } arb_req_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2
    } arb_state_e;

    // Next requester in round-robin order, wrapping ld back to st1.
    function automatic arb_req_e next_req(input arb_req_e r);
        case (r)
            REQ_ST1: return REQ_ST2;
            REQ_ST2: return REQ_LD;
            default: return REQ_ST1;
        endcase
    endfunction

endpackage

// File: rtl/lsq_mem_arbiter_if.sv
// Bundles the SQ/LQ requester, load-response, memory and status signals of the arbiter.
// Latency: none (wiring only).
// Backpressure: req held until gnt; memory throttles the arbiter through mem_ack.
interface lsq_mem_arbiter_if
    import lsq_pkg::*;
#(
    parameter int ADDR_W   = 64,
    parameter int DATA_W   = 64,
    parameter int LQ_IDX_W = 3
);
    logic                st1_req;
    logic [ADDR_W-1:0]   st1_addr;
    logic [DATA_W-1:0]   st1_data;
    logic                st1_gnt;
    logic                st2_req;
    logic [ADDR_W-1:0]   st2_addr;
    logic [DATA_W-1:0]   st2_data;
    logic                st2_gnt;
    logic                ld_req;
    logic [ADDR_W-1:0]   ld_addr;
    logic [LQ_IDX_W-1:0] ld_idx;
    logic                ld_gnt;
    logic                ld_squash;
    logic                ld_rvalid;
    logic [DATA_W-1:0]   ld_rdata;
    logic [LQ_IDX_W-1:0] ld_ridx;
    mem_cmd_e            mem_cmd;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic                mem_ack;
    logic                mem_rvalid;
    logic [DATA_W-1:0]   mem_rdata;
    logic                busy;
    logic                timeout_err;
`ifdef LSQ_MEM_ARB_PERF_EN
    logic [31:0]         perf_st1_cnt;
    logic [31:0]         perf_st2_cnt;
    logic [31:0]         perf_ld_cnt;
    logic [31:0]         perf_stall_cnt;
`endif

    // Arbiter side.
    modport master (
        input  st1_req, st1_addr, st1_data, st2_req, st2_addr, st2_data,
        input  ld_req, ld_addr, ld_idx, ld_squash,
        input  mem_ack, mem_rvalid, mem_rdata,
        output st1_gnt, st2_gnt, ld_gnt, ld_rvalid, ld_rdata, ld_ridx,
        output mem_cmd, mem_addr, mem_wdata, busy, timeout_err
`ifdef LSQ_MEM_ARB_PERF_EN
        , output perf_st1_cnt, perf_st2_cnt, perf_ld_cnt, perf_stall_cnt
`endif
    );

    // LSQ / memory side.
    modport slave (
        output st1_req, st1_addr, st1_data, st2_req, st2_addr, st2_data,
        output ld_req, ld_addr, ld_idx, ld_squash,
        output mem_ack, mem_rvalid, mem_rdata,
        input  st1_gnt, st2_gnt, ld_gnt, ld_rvalid, ld_rdata, ld_ridx,
        input  mem_cmd, mem_addr, mem_wdata, busy, timeout_err
`ifdef LSQ_MEM_ARB_PERF_EN
        , input perf_st1_cnt, perf_st2_cnt, perf_ld_cnt, perf_stall_cnt
`endif
    );

endinterface

// File: rtl/lsq_mem_arbiter_rr_arb3.sv
// Combinational 3-way round-robin picker: first requester at or after ptr wins.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; caller decides when the pick is consumed.
module rr_arb3
    import lsq_pkg::*;
(
    input  logic [2:0] req,
    input  arb_req_e   ptr,
    output logic [2:0] gnt,
    output arb_req_e   id,
    output logic       vld
);
    arb_req_e cand [3];

    // Scan candidates in priority order ptr, ptr+1, ptr+2 and take the first active one.
    always_comb begin
        cand[0] = ptr;
        cand[1] = next_req(ptr);
        cand[2] = next_req(cand[1]);
        gnt     = 3'b000;
        id      = REQ_ST1;
        vld     = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (!vld && req[cand[k]]) begin
                vld          = 1'b1;
                gnt[cand[k]] = 1'b1;
                id           = cand[k];
            end
        end
    end

endmodule

// File: rtl/lsq_mem_arbiter.sv
// Round-robin sequencer of the single D-memory port between SQ thread 1/2 drains and LQ misses.
// Latency: req in IDLE -> mem_cmd next cycle; gnt same cycle as mem_ack; ld_rvalid 1 cycle after mem_rvalid.
// Backpressure: one transaction at a time, held until mem_ack; timeout after MAX_WAIT cycles. Optional: LSQ_MEM_ARB_PERF_EN.
module lsq_mem_arbiter
    import lsq_pkg::*;
#(
    parameter int ADDR_W   = 64,   // must match the bound interface
    parameter int DATA_W   = 64,
    parameter int LQ_IDX_W = 3,
    parameter int MAX_WAIT = 64
)(
    input  logic               clock,
    input  logic               reset,
    lsq_mem_arbiter_if.master  bus
);
    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    arb_state_e          state;
    arb_req_e            rr_ptr;
    arb_req_e            owner;
    logic [ADDR_W-1:0]   own_addr;
    logic [DATA_W-1:0]   own_data;
    logic [LQ_IDX_W-1:0] own_idx;
    logic [CNT_W-1:0]    wait_cnt;
    logic                squash_seen;
    logic                timeout_q;
    logic                rvalid_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [LQ_IDX_W-1:0] ridx_q;

    logic [2:0] pick_gnt;
    arb_req_e   pick_id;
    logic       pick_vld;
    logic       acked;
    logic       expired;

    rr_arb3 u_rr (
        .req ({bus.ld_req, bus.st2_req, bus.st1_req}),
        .ptr (rr_ptr),
        .gnt (pick_gnt),
        .id  (pick_id),
        .vld (pick_vld)
    );

    assign acked   = (state == ISSUE) && bus.mem_ack;
    assign expired = (wait_cnt == CNT_W'(MAX_WAIT - 1));

    // Command is presented only while issuing; loads carry zero write data via own_data.
    assign bus.mem_cmd   = (state != ISSUE) ? NONE : ((owner == REQ_LD) ? LOAD : STORE);
    assign bus.mem_addr  = (state == ISSUE) ? own_addr : '0;
    assign bus.mem_wdata = (state == ISSUE) ? own_data : '0;

    assign bus.st1_gnt     = acked && (owner == REQ_ST1);
    assign bus.st2_gnt     = acked && (owner == REQ_ST2);
    assign bus.ld_gnt      = acked && (owner == REQ_LD);
    assign bus.busy        = (state != IDLE);
    assign bus.timeout_err = timeout_q;
    assign bus.ld_rvalid   = rvalid_q;
    assign bus.ld_rdata    = rdata_q;
    assign bus.ld_ridx     = ridx_q;

    // Main sequencer: select, issue, await read data, with a per-phase timeout.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            rr_ptr      <= REQ_ST1;
            owner       <= REQ_ST1;
            own_addr    <= '0;
            own_data    <= '0;
            own_idx     <= '0;
            wait_cnt    <= '0;
            squash_seen <= 1'b0;
            timeout_q   <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            ridx_q      <= '0;
        end else begin
            rvalid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        owner    <= pick_id;
                        wait_cnt <= '0;
                        state    <= ISSUE;
                        if (pick_gnt[0]) begin
                            own_addr <= bus.st1_addr;
                            own_data <= bus.st1_data;
                        end else if (pick_gnt[1]) begin
                            own_addr <= bus.st2_addr;
                            own_data <= bus.st2_data;
                        end else begin
                            own_addr <= bus.ld_addr;
                            own_data <= '0;
                            own_idx  <= bus.ld_idx;
                        end
                    end
                end
                ISSUE: begin
                    if (bus.mem_ack) begin
                        rr_ptr <= next_req(owner);
                        if (owner == REQ_LD) begin
                            wait_cnt    <= '0;
                            squash_seen <= 1'b0;
                            state       <= WAIT_RD;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (expired) begin
                        timeout_q <= 1'b1;
                        rr_ptr    <= next_req(owner);
                        state     <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                WAIT_RD: begin
                    if (bus.mem_rvalid) begin
                        rdata_q  <= bus.mem_rdata;
                        ridx_q   <= own_idx;
                        rvalid_q <= !(squash_seen || bus.ld_squash);
                        state    <= IDLE;
                    end else if (expired) begin
                        timeout_q <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                        if (bus.ld_squash) squash_seen <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LSQ_MEM_ARB_PERF_EN
    logic [31:0] perf_st1, perf_st2, perf_ld, perf_stall;

    // Saturating grant and issue-stall counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_st1   <= '0;
            perf_st2   <= '0;
            perf_ld    <= '0;
            perf_stall <= '0;
        end else begin
            if (bus.st1_gnt && perf_st1 != '1) perf_st1 <= perf_st1 + 32'd1;
            if (bus.st2_gnt && perf_st2 != '1) perf_st2 <= perf_st2 + 32'd1;
            if (bus.ld_gnt  && perf_ld  != '1) perf_ld  <= perf_ld  + 32'd1;
            if (state == ISSUE && !bus.mem_ack && perf_stall != '1)
                perf_stall <= perf_stall + 32'd1;
        end
    end

    assign bus.perf_st1_cnt   = perf_st1;
    assign bus.perf_st2_cnt   = perf_st2;
    assign bus.perf_ld_cnt    = perf_ld;
    assign bus.perf_stall_cnt = perf_stall;
`endif

endmodule

// File: tb/tb_lsq_mem_arbiter.sv
// Directed bench for lsq_mem_arbiter: store, load, fairness, squash, timeout and reset cases.
// Latency: inputs driven 2 time units after posedge, outputs sampled 1 unit later.
// Backpressure: mem_ack / mem_rvalid driven explicitly per step.
module tb_lsq_mem_arbiter;
    import lsq_pkg::*;

    logic clock;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    lsq_mem_arbiter_if #(.ADDR_W(64), .DATA_W(64), .LQ_IDX_W(3)) bif ();

    lsq_mem_arbiter #(.ADDR_W(64), .DATA_W(64), .LQ_IDX_W(3), .MAX_WAIT(64)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bif)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic cyc();
        @(posedge clock);
        #2;
    endtask

    task automatic chkw(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    logic [2:0] exp_g  [9] = '{3'b000, 3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b000, 3'b001};
    logic       exp_rv [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [2:0] g;

    initial begin
        reset = 1'b1;
        bif.st1_req = 1'b0; bif.st1_addr = '0; bif.st1_data = '0;
        bif.st2_req = 1'b0; bif.st2_addr = '0; bif.st2_data = '0;
        bif.ld_req = 1'b0;  bif.ld_addr = '0;  bif.ld_idx = '0; bif.ld_squash = 1'b0;
        bif.mem_ack = 1'b0; bif.mem_rvalid = 1'b0; bif.mem_rdata = '0;
        cyc(); cyc();
        reset = 1'b0;
        #1;
        chk1("rst_busy", bif.busy, 1'b0);
        chkw("rst_cmd", 64'(bif.mem_cmd), 64'(NONE));
        chk1("rst_timeout", bif.timeout_err, 1'b0);
        chk1("rst_rvalid", bif.ld_rvalid, 1'b0);
        chkw("rst_gnt", 64'({bif.ld_gnt, bif.st2_gnt, bif.st1_gnt}), 64'd0);

        // Store from st1: selection cycle, two ISSUE cycles, ack on the second.
        cyc();
        bif.st1_req = 1'b1; bif.st1_addr = 64'h100; bif.st1_data = 64'hAB;
        #1 chkw("st_c0_cmd", 64'(bif.mem_cmd), 64'(NONE));
        cyc();
        bif.st1_data = 64'h55;
        #1;
        chkw("st_c1_cmd", 64'(bif.mem_cmd), 64'(STORE));
        chkw("st_c1_addr", bif.mem_addr, 64'h100);
        chkw("st_c1_wdata", bif.mem_wdata, 64'hAB);
        chk1("st_c1_gnt", bif.st1_gnt, 1'b0);
        cyc();
        bif.mem_ack = 1'b1;
        #1;
        chk1("st_c2_gnt", bif.st1_gnt, 1'b1);
        chkw("st_c2_wdata", bif.mem_wdata, 64'hAB);
        cyc();
        bif.st1_req = 1'b0; bif.mem_ack = 1'b0;
        #1;
        chk1("st_c3_gnt", bif.st1_gnt, 1'b0);
        chk1("st_c3_busy", bif.busy, 1'b0);

        // Load: ack immediately, data 3 cycles after the ack cycle.
        cyc();
        bif.ld_req = 1'b1; bif.ld_addr = 64'h200; bif.ld_idx = 3'd5;
        cyc();
        bif.mem_ack = 1'b1;
        #1;
        chkw("ld_c1_cmd", 64'(bif.mem_cmd), 64'(LOAD));
        chkw("ld_c1_addr", bif.mem_addr, 64'h200);
        chkw("ld_c1_wdata", bif.mem_wdata, 64'd0);
        chk1("ld_c1_gnt", bif.ld_gnt, 1'b1);
        cyc();
        bif.ld_req = 1'b0; bif.mem_ack = 1'b0;
        #1;
        chkw("ld_c2_cmd", 64'(bif.mem_cmd), 64'(NONE));
        chk1("ld_c2_busy", bif.busy, 1'b1);
        cyc();
        cyc();
        bif.mem_rvalid = 1'b1; bif.mem_rdata = 64'hDEAD;
        #1 chk1("ld_c4_rvalid", bif.ld_rvalid, 1'b0);
        cyc();
        bif.mem_rvalid = 1'b0;
        #1;
        chk1("ld_c5_rvalid", bif.ld_rvalid, 1'b1);
        chkw("ld_c5_rdata", bif.ld_rdata, 64'hDEAD);
        chkw("ld_c5_ridx", 64'(bif.ld_ridx), 64'd5);
        chk1("ld_c5_busy", bif.busy, 1'b0);
        cyc();
        #1 chk1("ld_c6_rvalid", bif.ld_rvalid, 1'b0);

        // Fairness: all requests held, ack and rvalid always high.
        cyc();
        bif.st1_req = 1'b1; bif.st2_req = 1'b1; bif.ld_req = 1'b1;
        bif.mem_ack = 1'b1; bif.mem_rvalid = 1'b1; bif.mem_rdata = 64'hCAFE;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) cyc();
            #1;
            g = {bif.ld_gnt, bif.st2_gnt, bif.st1_gnt};
            chkw($sformatf("rr_gnt_c%0d", i), 64'(g), 64'(exp_g[i]));
            chk1($sformatf("rr_rvalid_c%0d", i), bif.ld_rvalid, exp_rv[i]);
        end
        cyc();
        bif.st1_req = 1'b0; bif.st2_req = 1'b0; bif.ld_req = 1'b0;
        bif.mem_ack = 1'b0; bif.mem_rvalid = 1'b0;

        // Squashed load, followed by an st2 store that must still be served.
        cyc();
        bif.ld_req = 1'b1; bif.ld_addr = 64'h300; bif.ld_idx = 3'd3;
        cyc();
        bif.mem_ack = 1'b1;
        #1 chk1("sq_c1_gnt", bif.ld_gnt, 1'b1);
        cyc();
        bif.ld_req = 1'b0; bif.mem_ack = 1'b0; bif.ld_squash = 1'b1;
        cyc();
        bif.ld_squash = 1'b0;
        cyc();
        bif.mem_rvalid = 1'b1; bif.mem_rdata = 64'hBEEF;
        cyc();
        bif.mem_rvalid = 1'b0;
        bif.st2_req = 1'b1; bif.st2_addr = 64'h400; bif.st2_data = 64'h77;
        #1;
        chk1("sq_c5_rvalid", bif.ld_rvalid, 1'b0);
        chk1("sq_c5_busy", bif.busy, 1'b0);
        cyc();
        bif.mem_ack = 1'b1;
        #1;
        chk1("sq_st2_gnt", bif.st2_gnt, 1'b1);
        chkw("sq_st2_addr", bif.mem_addr, 64'h400);
        cyc();
        bif.st2_req = 1'b0; bif.mem_ack = 1'b0;

        // Timeout: st1 issued, never acked for 64 ISSUE cycles.
        cyc();
        bif.st1_req = 1'b1; bif.st1_addr = 64'h500;
        for (int i = 1; i <= 64; i++) begin
            cyc();
            #1 chk1($sformatf("to_nognt_c%0d", i), bif.st1_gnt, 1'b0);
        end
        chk1("to_c64_busy", bif.busy, 1'b1);
        chk1("to_c64_err", bif.timeout_err, 1'b0);
        cyc();
        bif.st1_req = 1'b0;
        #1;
        chk1("to_c65_busy", bif.busy, 1'b0);
        chk1("to_c65_err", bif.timeout_err, 1'b1);
        // Pointer moved past st1, so st2 wins a tie with st1.
        cyc();
        bif.st1_req = 1'b1; bif.st2_req = 1'b1;
        cyc();
        bif.mem_ack = 1'b1;
        #1;
        chk1("to_ptr_st2", bif.st2_gnt, 1'b1);
        chk1("to_ptr_st1", bif.st1_gnt, 1'b0);
        chk1("to_sticky", bif.timeout_err, 1'b1);
        cyc();
        bif.st1_req = 1'b0; bif.st2_req = 1'b0; bif.mem_ack = 1'b0;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        #1 chk1("to_rst_clear", bif.timeout_err, 1'b0);

        // Reset while waiting for read data abandons the load.
        cyc();
        bif.ld_req = 1'b1; bif.ld_addr = 64'h600; bif.ld_idx = 3'd6;
        cyc();
        bif.mem_ack = 1'b1;
        cyc();
        bif.ld_req = 1'b0; bif.mem_ack = 1'b0;
        #1 chk1("rw_wait_busy", bif.busy, 1'b1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        bif.mem_rvalid = 1'b1; bif.mem_rdata = 64'h1234;
        #1;
        chk1("rw_busy", bif.busy, 1'b0);
        chkw("rw_cmd", 64'(bif.mem_cmd), 64'(NONE));
        chk1("rw_rvalid", bif.ld_rvalid, 1'b0);
        chkw("rw_gnt", 64'({bif.ld_gnt, bif.st2_gnt, bif.st1_gnt}), 64'd0);
        cyc();
        bif.mem_rvalid = 1'b0;
        #1 chk1("rw_late_rvalid", bif.ld_rvalid, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lsq_mem_arbiter.md
Name: lsq_mem_arbiter

Overview:
- Sequences the single data-memory port between three requesters: store-queue thread 1 commit drain, store-queue thread 2 commit drain, and load-queue misses.
- Sits between the LSQ (SQ heads and LQ issue) and the D-memory interface.
- Arbitrates round-robin and runs one memory transaction at a time.
- Returns store-accept pulses to the SQ and load data to the LQ, tagged with the LQ index.

Parameters:
ADDR_W, 64, memory address width
DATA_W, 64, store/load data width
LQ_IDX_W, 3, width of the load-queue entry tag
MAX_WAIT, 64, cycles allowed in ISSUE or WAIT_RD before the transaction is abandoned

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
st1_req  in  1  thread-1 SQ head is committed and ready to write
st1_addr  in  ADDR_W  thread-1 store address
st1_data  in  DATA_W  thread-1 store data
st1_gnt  out  1  thread-1 store accepted by memory; SQ advances head
st2_req/st2_addr/st2_data/st2_gnt  same widths  thread-2 equivalents
ld_req  in  1  LQ load miss request
ld_addr  in  ADDR_W  load address
ld_idx  in  LQ_IDX_W  LQ entry tag
ld_gnt  out  1  load accepted by memory
ld_squash  in  1  mispredict: drop any outstanding load response
ld_rvalid  out  1  load data valid
ld_rdata  out  DATA_W  returned load data
ld_ridx  out  LQ_IDX_W  tag of returned load
mem_cmd  out  2  0=NONE, 1=LOAD, 2=STORE
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  store data
mem_ack  in  1  memory accepts the command this cycle
mem_rvalid  in  1  load response valid
mem_rdata  in  DATA_W  load response data
busy  out  1  state != IDLE
timeout_err  out  1  sticky timeout flag

Behaviour:
- Clocking: single clock `clock`; reset is synchronous, active-high `reset`.
- Reset:
  - state=IDLE; rr_ptr=0 (st1).
  - All outputs 0; mem_cmd=NONE.
  - Wait counter 0; timeout_err cleared.
  - Reset mid-transaction abandons it silently: no gnt, no rvalid.
- State IDLE:
  - If any req is high, pick the winner in the order rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3; 0=st1, 1=st2, 2=ld).
  - Latch the winner's addr/data/idx into owner registers and go to ISSUE.
  - If no req, stay in IDLE.
- State ISSUE:
  - Drive mem_cmd/mem_addr/mem_wdata from the latched registers (mem_wdata=0 for loads).
  - On mem_ack, assert the owner's gnt combinationally in the same cycle.
  - Then rr_ptr=owner+1 mod 3.
  - Store owner: go to IDLE. Load owner: go to WAIT_RD.
- State WAIT_RD:
  - mem_cmd=NONE.
  - On mem_rvalid: register ld_rdata=mem_rdata and ld_ridx=latched idx; ld_rvalid pulses 1 cycle later unless dropped; go to IDLE.
  - A response is dropped if ld_squash is seen in any WAIT_RD cycle, including the mem_rvalid cycle.
  - ld_squash in ISSUE or IDLE has no effect; LQ stores are not squashed.
- Latency:
  - req in IDLE at cycle N gives mem_cmd at N+1.
  - Minimum store turnaround is 2 cycles per store; back-to-back requests always pass one IDLE cycle.
- Requester rules:
  - Requesters hold req until gnt.
  - Fields are sampled only in the IDLE selection cycle; later changes are ignored.
- Fairness: with all three reqs held continuously, grant order is st1, st2, ld, st1, and so on.
- Timeout:
  - The wait counter resets on entry to ISSUE/WAIT_RD and increments each cycle there.
  - On reaching MAX_WAIT: set timeout_err (sticky until reset), go to IDLE, no gnt/rvalid, rr_ptr advances past the owner.
- Simultaneous events: mem_rvalid outside WAIT_RD is ignored.

Optional Feature:
LSQ_MEM_ARB_PERF_EN
- Defined: adds outputs perf_st1_cnt, perf_st2_cnt, perf_ld_cnt (32b each), counting gnt pulses, and perf_stall_cnt (32b), counting cycles in ISSUE without mem_ack.
  - Counters saturate at all-ones and reset to 0.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package lsq_pkg holds:
  - MEM_CMD enum (NONE/LOAD/STORE)
  - ARB_REQ enum (REQ_ST1/REQ_ST2/REQ_LD)
  - ARB_STATE enum (IDLE/ISSUE/WAIT_RD)
- Sub-module rr_arb3: combinational 3-way round-robin picker taking req[2:0] and ptr, returning a one-hot grant and an id.

Test Plan:
- st1_req=1, addr=0x100, data=0xAB, mem_ack at cycle 2 -> mem_cmd=STORE, addr 0x100, wdata 0xAB at cycles 1-2; st1_gnt=1 at cycle 2 only.
- ld_req=1, addr=0x200, idx=5, ack immediately, mem_rvalid 3 cycles later with 0xDEAD -> ld_rvalid=1, rdata=0xDEAD, ridx=5 one cycle after mem_rvalid.
- All three reqs held, mem_ack always 1 -> grant order st1, st2, ld, st1; one grant every 2 cycles for stores.
- Load in WAIT_RD, ld_squash pulse, then mem_rvalid -> ld_rvalid stays 0; state returns to IDLE; next st2 request is served.
- mem_ack held 0 for MAX_WAIT cycles -> timeout_err=1, busy=0, no gnt; reset then clears timeout_err.
- Reset asserted while in WAIT_RD -> all outputs 0 next cycle; later mem_rvalid produces no ld_rvalid.
